// File: rtl/alu_cmd_issue_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_issue_if
// Handshake bundle for the ALU command issue stage.
//   Command channel : cmd_valid, cmd_ready, cmd_a[7:0], cmd_b[7:0], cmd_op[3:0]
//   Result channel  : res_valid, res_ready, res_data[15:0], res_op[3:0], res_err
// Modports:
//   master - command producer / result consumer (drives cmd_*, res_ready)
//   slave  - the issue stage (drives cmd_ready, res_*)
// ---------------------------------------------------------------------------
interface alu_cmd_issue_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [3:0]  cmd_op;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [3:0]  res_op;
    logic        res_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
        input  cmd_ready, res_valid, res_data, res_op, res_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
        output cmd_ready, res_valid, res_data, res_op, res_err
    );
endinterface

// File: rtl/alu_cmd_issue.sv
// ---------------------------------------------------------------------------
// alu_cmd_issue
// Command issue/capture stage in front of an 8-bit combinational ALU.
// Commands are buffered in a DEPTH-entry FIFO, issued one at a time onto the
// ALU ports for exactly one cycle, and the 16-bit result is registered and
// offered on a valid/ready result channel tagged with its opcode.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   bus        slave modport of alu_cmd_issue_if (cmd_* and res_* channels)
//   alu_a      out  ALU operand a (registered)
//   alu_b      out  ALU operand b (registered)
//   alu_com    out  ALU opcode (registered)
//   alu_en     out  ALU enable; ALU output is high-Z while low
//   alu_y      in   ALU result, sampled only while issuing
//   cmd_count  out  FIFO occupancy, 0..DEPTH
//
// Optional feature: define ALU_DIV0_GUARD_EN to suppress MOD/DIV by zero.
// The ALU is then left disabled and the result is forced to 16'hFFFF with
// res_err set. Without the macro every command is issued and res_err is 0.
// ---------------------------------------------------------------------------
module alu_cmd_issue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_issue_if.slave       bus,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [3:0]           alu_com,
    output logic                 alu_en,
    input  logic [15:0]          alu_y,
    output logic [CNT_W-1:0]     cmd_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    logic [1:0]       state;
    logic [7:0]       mem_a  [DEPTH];
    logic [7:0]       mem_b  [DEPTH];
    logic [3:0]       mem_op [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             load;
    logic             div0;
    logic [15:0]      issue_data;
    logic             res_valid_q;
    logic [15:0]      res_data_q;
    logic [3:0]       res_op_q;

    // Full blocks pushes even when the head is being popped this cycle.
    assign bus.cmd_ready = (count != CNT_W'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == ISSUE);
    assign cmd_count     = count;

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_op    = res_op_q;

    // Operand registers take the FIFO head on every entry into ISSUE. In
    // RESULT the previous head was already popped, so count is post-pop.
    always_comb begin
        load = 1'b0;
        if (state == IDLE && count != '0)
            load = 1'b1;
        else if (state == RESULT && res_valid_q && bus.res_ready && count != '0)
            load = 1'b1;
    end

`ifdef ALU_DIV0_GUARD_EN
    logic res_err_q;

    assign div0       = (alu_com == 4'b0000 || alu_com == 4'b0100) && alu_b == 8'd0;
    assign issue_data = div0 ? 16'hFFFF : alu_y;
    assign bus.res_err = res_err_q;

    always_ff @(posedge clk) begin
        if (rst)
            res_err_q <= 1'b0;
        else if (state == ISSUE)
            res_err_q <= div0;
    end
`else
    assign div0        = 1'b0;
    assign issue_data  = alu_y;
    assign bus.res_err = 1'b0;
`endif

    // alu_y is only looked at in ISSUE, so a floating bus elsewhere is harmless.
    assign alu_en = (state == ISSUE) && !div0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= bus.cmd_a;
            mem_b[wr_ptr]  <= bus.cmd_b;
            mem_op[wr_ptr] <= bus.cmd_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_com     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (load) begin
                alu_a   <= mem_a[rd_ptr];
                alu_b   <= mem_b[rd_ptr];
                alu_com <= mem_op[rd_ptr];
            end

            case (state)
                IDLE: begin
                    if (count != '0)
                        state <= ISSUE;
                end
                ISSUE: begin
                    res_data_q  <= issue_data;
                    res_op_q    <= alu_com;
                    res_valid_q <= 1'b1;
                    state       <= RESULT;
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= (count != '0) ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
